// File: rtl/bomb_pkg.sv
// Shared types and default tuning constants for the bomb control path.
// Timer preset lives here so the controller and the timer instance agree.
package bomb_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, EXPLODE, COOLDOWN} bomb_state_t;

  localparam int         EXPLODE_FRAMES_DEF    = 30;
  localparam logic [3:0] BLINK_THRESHOLD_DEF   = 4'd2;
  localparam int         BLINK_HALF_FRAMES_DEF = 8;
  localparam logic [3:0] RADIUS_MAX_DEF        = 4'd15;
  localparam logic [3:0] TIMER_PRESET          = 4'h3;

endpackage

// File: rtl/frame_pulse_counter.sv
// Counts startOfFrame pulses and wraps to 0 after TERMINAL of them; done flags the wrapping pulse.
// done is combinational in the cycle of the TERMINAL-th pulse; clear has priority, no backpressure.
module frame_pulse_counter #(
  parameter int TERMINAL = 8,
  parameter int W        = 3
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic startOfFrame,
  output logic done
);

  logic [W-1:0] count;
  logic         atEnd;

  assign atEnd = (count == W'(TERMINAL - 1));
  assign done  = startOfFrame && !clear && atEnd;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (startOfFrame) begin
      count <= atEnd ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/bomb_controller.sv
// Plant/arm/blink/explode/defuse sequencing around the bomb countdown timer.
// Draw outputs registered (1-cycle); timer strobes decoded from state; no backpressure.
module bomb_controller
  import bomb_pkg::*;
#(
  parameter int         EXPLODE_FRAMES    = EXPLODE_FRAMES_DEF,
  parameter logic [3:0] BLINK_THRESHOLD   = BLINK_THRESHOLD_DEF,
  parameter int         BLINK_HALF_FRAMES = BLINK_HALF_FRAMES_DEF,
  parameter logic [3:0] RADIUS_MAX        = RADIUS_MAX_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       oneSecPulse,
  input  logic       plantReq,
  input  logic       defuseReq,
  input  logic [3:0] timerCount,
  input  logic       timerTc,
  output logic       timerLoadN,
  output logic       timerEnable,
  output logic       bombVisible,
  output logic       blinkOn,
  output logic       exploding,
  output logic [3:0] explosionRadius,
  output logic       bombExploded,
  output logic       busy
);

  localparam int FRAME_W = $clog2(EXPLODE_FRAMES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_FRAMES);

  bomb_state_t state;
  logic        blinkHold;
  logic        blinkDone;
  logic        explodeDone;

  // Blink phase only advances once the count is in the warning zone.
  assign blinkHold = (state != ARMED) || (timerCount > BLINK_THRESHOLD);

  frame_pulse_counter #(.TERMINAL(BLINK_HALF_FRAMES), .W(BLINK_W)) u_blink (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (blinkHold),
    .startOfFrame (startOfFrame),
    .done         (blinkDone)
  );

  frame_pulse_counter #(.TERMINAL(EXPLODE_FRAMES), .W(FRAME_W)) u_explode (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (state != EXPLODE),
    .startOfFrame (startOfFrame),
    .done         (explodeDone)
  );

  assign timerLoadN  = (state != LOAD);
  assign timerEnable = (state == ARMED) && oneSecPulse && !defuseReq;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state           <= IDLE;
      bombVisible     <= 1'b0;
      blinkOn         <= 1'b0;
      exploding       <= 1'b0;
      explosionRadius <= 4'd0;
      bombExploded    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      bombExploded <= 1'b0;
      case (state)
        IDLE: begin
          if (plantReq) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          // Timer latches its preset on this edge; timerTc is stale here.
          state       <= ARMED;
          bombVisible <= 1'b1;
          blinkOn     <= 1'b1;
        end
        ARMED: begin
          if (defuseReq) begin
            state       <= IDLE;
            bombVisible <= 1'b0;
            blinkOn     <= 1'b0;
            busy        <= 1'b0;
          end else if (timerTc) begin
            state           <= EXPLODE;
            bombVisible     <= 1'b0;
            blinkOn         <= 1'b0;
            exploding       <= 1'b1;
            explosionRadius <= 4'd0;
            bombExploded    <= 1'b1;
          end else if (timerCount > BLINK_THRESHOLD) begin
            blinkOn <= 1'b1;
          end else if (blinkDone) begin
            blinkOn <= !blinkOn;
          end
        end
        EXPLODE: begin
          if (explodeDone) begin
            state           <= COOLDOWN;
            exploding       <= 1'b0;
            explosionRadius <= 4'd0;
          end else if (startOfFrame && (explosionRadius != RADIUS_MAX)) begin
            explosionRadius <= explosionRadius + 4'd1;
          end
        end
        COOLDOWN: begin
          if (oneSecPulse) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Randomized plant/defuse traffic against a behavioural timer and a reference model;
// expected per-cycle observations are queued by the driver and checked by a negedge monitor.
module tb_bomb_controller;

  localparam int NCYC        = 20000;
  localparam int EXPL_FRAMES = 30;
  localparam int HALF        = 8;
  localparam int THR         = 2;
  localparam int RMAX        = 15;
  localparam int PRESET      = 3;

  localparam int P_IDLE = 0, P_LOAD = 1, P_ARMED = 2, P_EXPLODE = 3, P_COOLDOWN = 4;

  logic       clk;
  logic       resetN;
  logic       startOfFrame, oneSecPulse, plantReq, defuseReq;
  logic [3:0] timerCount;
  logic       timerTc;
  logic       timerLoadN, timerEnable, bombVisible, blinkOn, exploding;
  logic [3:0] explosionRadius;
  logic       bombExploded, busy;

  bomb_controller dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (startOfFrame),
    .oneSecPulse     (oneSecPulse),
    .plantReq        (plantReq),
    .defuseReq       (defuseReq),
    .timerCount      (timerCount),
    .timerTc         (timerTc),
    .timerLoadN      (timerLoadN),
    .timerEnable     (timerEnable),
    .bombVisible     (bombVisible),
    .blinkOn         (blinkOn),
    .exploding       (exploding),
    .explosionRadius (explosionRadius),
    .bombExploded    (bombExploded),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The countdown timer the controller drives: 9..0 down counter, enable2 tied high.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)          timerCount <= 4'd0;
    else if (!timerLoadN) timerCount <= bomb_pkg::TIMER_PRESET;
    else if (timerEnable) timerCount <= (timerCount == 4'd0) ? 4'd9 : timerCount - 4'd1;
  end
  assign timerTc = (timerCount == 4'd0);

  typedef struct packed {
    logic       loadN;
    logic       en;
    logic       vis;
    logic       blink;
    logic       expl;
    logic [3:0] rad;
    logic       boom;
    logic       busy;
    logic [3:0] cnt;
  } obs_t;

  obs_t expq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   dutBooms   = 0;
  int   modelBooms = 0;

  // Reference model: phase plus running totals; blink and radius derived arithmetically.
  int ph, cnt, lowFrames, efr;
  bit just;

  task automatic model_reset();
    ph = P_IDLE; cnt = 0; lowFrames = 0; efr = 0; just = 0;
  endtask

  function automatic obs_t expect_now(input bit sec, input bit def);
    obs_t e;
    e       = '0;
    e.loadN = (ph != P_LOAD);
    e.en    = (ph == P_ARMED) && sec && !def;
    e.vis   = (ph == P_ARMED);
    e.blink = (ph == P_ARMED) && (((lowFrames / HALF) % 2) == 0);
    e.expl  = (ph == P_EXPLODE);
    e.rad   = (ph == P_EXPLODE) ? 4'((efr > RMAX) ? RMAX : efr) : 4'd0;
    e.boom  = just;
    e.busy  = (ph != P_IDLE);
    e.cnt   = 4'(cnt);
    return e;
  endfunction

  task automatic model_step(input bit plant, input bit def, input bit sof, input bit sec);
    int oldPh;
    bit en;
    oldPh = ph;
    en    = (ph == P_ARMED) && sec && !def;
    just  = 0;
    case (ph)
      P_IDLE:    if (plant) ph = P_LOAD;
      P_LOAD:    begin ph = P_ARMED; lowFrames = 0; end
      P_ARMED: begin
        if (def) ph = P_IDLE;
        else if (cnt == 0) begin ph = P_EXPLODE; efr = 0; just = 1; end
        else if (cnt > THR) lowFrames = 0;
        else if (sof) lowFrames++;
      end
      P_EXPLODE: begin
        if (sof) begin
          efr++;
          if (efr == EXPL_FRAMES) begin ph = P_COOLDOWN; efr = 0; end
        end
      end
      P_COOLDOWN: if (sec) ph = P_IDLE;
      default:   ph = P_IDLE;
    endcase
    if (oldPh == P_LOAD) cnt = PRESET;
    else if (en)         cnt = (cnt == 0) ? 9 : cnt - 1;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (bombExploded === 1'b1) dutBooms++;
    if (expq.size() > 0) begin
      e       = expq.pop_front();
      a.loadN = timerLoadN;
      a.en    = timerEnable;
      a.vis   = bombVisible;
      a.blink = blinkOn;
      a.expl  = exploding;
      a.rad   = explosionRadius;
      a.boom  = bombExploded;
      a.busy  = busy;
      a.cnt   = timerCount;
      compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t got %b want %b (loadN en vis blink expl rad[4] boom busy cnt[4])",
                 $time, a, e);
      end
    end
  end

  initial begin
    int  plantHold, defHold;
    bit  sof, sec, plant, def, resetNow, raceDone, rstDone;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    oneSecPulse  = 1'b0;
    plantReq     = 1'b0;
    defuseReq    = 1'b0;
    plantHold    = 0;
    defHold      = 0;
    raceDone     = 0;
    rstDone      = 0;
    model_reset();

    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk);
      #1;
      sof = (k % 10) == 0;
      sec = (k % 100) == 50;

      if (plantHold > 0) plantHold--;
      else if ($urandom_range(0, 59) == 0) plantHold = int'($urandom_range(1, 800));
      plant = (plantHold > 0);

      if (defHold > 0) defHold--;
      else if ($urandom_range(0, 999) == 0) defHold = int'($urandom_range(1, 3));
      def = (defHold > 0);
      // Defuse racing the decrement pulse while the count reads 2.
      if (!raceDone && ph == P_ARMED && cnt == 2 && sec) begin
        def      = 1;
        raceDone = 1;
      end

      resetNow = 0;
      if (!rstDone && ph == P_EXPLODE && efr == 5) begin
        resetNow = 1;
        rstDone  = 1;
      end

      startOfFrame = sof;
      oneSecPulse  = sec;
      plantReq     = plant;
      defuseReq    = def;

      if (k < 3 || resetNow) begin
        resetN = 1'b0;
        model_reset();
        expq.push_back(expect_now(sec, def));
      end else begin
        resetN = 1'b1;
        expq.push_back(expect_now(sec, def));
        if (just) modelBooms++;
        model_step(plant, def, sof, sec);
      end
    end

    @(negedge clk);
    #1;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, want 0", expq.size());
    end
    compared++;
    if (dutBooms != modelBooms) begin
      mismatched++;
      $display("FAIL explosions: got %0d bombExploded pulses, want %0d", dutBooms, modelBooms);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
